pattern_pkt_gen: RTL and testbench

PATTERN_PKT_GEN -- requirements
Module: pattern_pkt_gen

---
 rtl/pattern_pkt_gen_pkg.sv | 25 ++
 rtl/pattern_pkt_gen_word_fmt.sv | 54 +++++
 rtl/pattern_pkt_gen.sv | 168 ++++++++++++++++
 tb/tb_pattern_pkt_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkt_gen_pkg.sv
// Shared encodings and constants for the pattern packet generator.
package pattern_pkt_gen_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MODHDR  = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  localparam logic [7:0] CTRL_MODHDR = 8'hFF;
  localparam logic [7:0] CTRL_LAST   = 8'h01;
  localparam logic [7:0] CTRL_NONE   = 8'h00;

  localparam int NUM_HDR_WORDS = 3;

  localparam logic [63:0] HDR_WORD0 = 64'hDA7A_0000_0000_0001;
  localparam logic [63:0] HDR_WORD1 = 64'h5A5A_0000_0000_0002;
  localparam logic [63:0] HDR_WORD2 = 64'hC0DE_0000_0000_0003;

  // Packet length in words: module header is not counted, the 3 header words are.
  function automatic logic [15:0] word_len(input logic [7:0] payload_words);
    return 16'(NUM_HDR_WORDS) + {8'h00, payload_words};
  endfunction

endpackage

// File: rtl/pattern_pkt_gen_word_fmt.sv
// Output word mux: purely combinational from state, word index and latched config.
import pattern_pkt_gen_pkg::*;

module pkt_word_fmt #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic [2:0]            state,
  input  logic [7:0]            idx,
  input  logic [15:0]           dst_port,
  input  logic [7:0]            payload_words,
  input  logic [7:0]            pat_idx,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [31:0]           pkt_seq,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CTRL_WIDTH-1:0] ctrl
);

  logic [63:0] w;
  logic [7:0]  c;
  logic [15:0] wl;
  logic        use_pat;

  always_comb begin
    w       = '0;
    c       = CTRL_NONE;
    wl      = word_len(payload_words);
    use_pat = 1'b0;
    case (state)
      ST_MODHDR: begin
        w = {dst_port, wl, 16'h0000, wl[12:0], 3'b000};
        c = CTRL_MODHDR;
      end
      ST_HDR: begin
        case (idx[1:0])
          2'd0:    w = HDR_WORD0;
          2'd1:    w = HDR_WORD1;
          2'd2:    w = HDR_WORD2;
          default: w = '0;
        endcase
      end
      ST_PAYLOAD: begin
        // pat_idx beyond the payload never matches, so the pattern is simply omitted
        use_pat = (idx == pat_idx);
        w       = {pkt_seq, 24'h000000, idx};
        c       = (idx == payload_words - 8'd1) ? CTRL_LAST : CTRL_NONE;
      end
      default: ;
    endcase
    data = use_pat ? pattern : DATA_WIDTH'(w);
    ctrl = CTRL_WIDTH'(c);
  end

endmodule

// File: rtl/pattern_pkt_gen.sv
// Burst packet generator: FSM, burst/gap counters and packet counter.
import pattern_pkt_gen_pkg::*;

module pattern_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [7:0]            cfg_payload_words,
  input  logic [7:0]            cfg_pat_idx,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic [7:0]            cfg_gap,
  input  logic [15:0]           cfg_dst_port,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic [31:0]           pkts_sent,
  input  logic                  clear_cnt
);

  logic [2:0]            state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [31:0]           pkts_sent_q, pkts_sent_d;
  logic [31:0]           pkt_seq_q, pkt_seq_d;
  logic [15:0]           num_pkts_q, num_pkts_d;
  logic [7:0]            plw_q, plw_d;
  logic [7:0]            pat_idx_q, pat_idx_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [7:0]            gap_q, gap_d;
  logic [15:0]           dst_q, dst_d;

  logic active, last_word, pkt_done, stop;
  logic [15:0] cnt_after;

  assign active    = (state_q == ST_MODHDR) || (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
  assign out_wr    = active & out_rdy;
  assign busy      = (state_q != ST_IDLE);
  assign pkts_sent = pkts_sent_q;
  assign last_word = (state_q == ST_PAYLOAD) && (idx_q == plw_q - 8'd1);
  assign pkt_done  = out_wr & last_word;
  assign cnt_after = pkt_done ? burst_cnt_q + 16'd1 : burst_cnt_q;
  // An abort arriving on the deciding cycle itself still ends the burst.
  assign stop      = ((num_pkts_q != 16'd0) && (cnt_after >= num_pkts_q)) || abort_pend_q || abort;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    burst_cnt_d  = cnt_after;
    abort_pend_d = abort_pend_q | (abort & busy);
    pkt_seq_d    = pkt_seq_q;
    num_pkts_d   = num_pkts_q;
    plw_d        = plw_q;
    pat_idx_d    = pat_idx_q;
    pattern_d    = pattern_q;
    gap_d        = gap_q;
    dst_d        = dst_q;
    pkts_sent_d  = clear_cnt ? 32'd0 : (pkt_done ? pkts_sent_q + 32'd1 : pkts_sent_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_pkts_d   = cfg_num_pkts;
          plw_d        = (cfg_payload_words == 8'd0) ? 8'd1 : cfg_payload_words;
          pat_idx_d    = cfg_pat_idx;
          pattern_d    = cfg_pattern;
          gap_d        = cfg_gap;
          dst_d        = cfg_dst_port;
          burst_cnt_d  = 16'd0;
          abort_pend_d = abort;
          idx_d        = 8'd0;
          state_d      = ST_MODHDR;
        end
      end
      ST_MODHDR: begin
        if (out_wr) begin
          pkt_seq_d = pkts_sent_q;
          idx_d     = 8'd0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_wr) begin
          if (idx_q == 8'(NUM_HDR_WORDS - 1)) begin
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (out_wr) begin
          idx_d = last_word ? 8'd0 : idx_q + 8'd1;
          if (last_word) begin
            if (gap_q != 8'd0) begin
              gap_cnt_d = gap_q - 8'd1;
              state_d   = ST_GAP;
            end else begin
              state_d = stop ? ST_IDLE : ST_MODHDR;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = stop ? ST_IDLE : ST_MODHDR;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) abort_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      abort_pend_q <= 1'b0;
      pkts_sent_q  <= '0;
      pkt_seq_q    <= '0;
      num_pkts_q   <= '0;
      plw_q        <= '0;
      pat_idx_q    <= '0;
      pattern_q    <= '0;
      gap_q        <= '0;
      dst_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      abort_pend_q <= abort_pend_d;
      pkts_sent_q  <= pkts_sent_d;
      pkt_seq_q    <= pkt_seq_d;
      num_pkts_q   <= num_pkts_d;
      plw_q        <= plw_d;
      pat_idx_q    <= pat_idx_d;
      pattern_q    <= pattern_d;
      gap_q        <= gap_d;
      dst_q        <= dst_d;
    end
  end

  pkt_word_fmt #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_fmt (
    .state         (state_q),
    .idx           (idx_q),
    .dst_port      (dst_q),
    .payload_words (plw_q),
    .pat_idx       (pat_idx_q),
    .pattern       (pattern_q),
    .pkt_seq       (pkt_seq_q),
    .data          (out_data),
    .ctrl          (out_ctrl)
  );

endmodule

// File: tb/tb_pattern_pkt_gen.sv
// Self-checking bench: word-stream scoreboard built from the packet format rules.
module tb_pattern_pkt_gen;
  import pattern_pkt_gen_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic        out_rdy = 1'b0, clear_cnt = 1'b0;
  logic [15:0] cfg_num_pkts = '0, cfg_dst_port = '0;
  logic [7:0]  cfg_payload_words = '0, cfg_pat_idx = '0, cfg_gap = '0;
  logic [63:0] cfg_pattern = '0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, busy;
  logic [31:0] pkts_sent;

  int total = 0, bad = 0;
  int rdy_mode = 0, chk_gap = 0, cyc = 0, last_end = -1, gap_m = 0;
  int cap_n = 0, pkts_seen = 0, word_in_pkt = 0;
  logic [31:0] exp_sent = '0;
  logic [71:0] exp_q[$];
  logic [7:0]  cap_ctrl[64];
  logic [63:0] cap_data[64];

  always #5 clk = ~clk;

  pattern_pkt_gen #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_num_pkts(cfg_num_pkts), .cfg_payload_words(cfg_payload_words),
    .cfg_pat_idx(cfg_pat_idx), .cfg_pattern(cfg_pattern), .cfg_gap(cfg_gap),
    .cfg_dst_port(cfg_dst_port), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .busy(busy), .pkts_sent(pkts_sent),
    .clear_cnt(clear_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected packet as a list of {ctrl, data} words.
  task automatic push_pkt(input logic [31:0] seq, input int p, input int pi,
                          input logic [15:0] dst, input logic [63:0] pat);
    int wl = 3 + p;
    exp_q.push_back({8'hFF, dst, 16'(wl), 16'h0000, 16'(wl * 8)});
    exp_q.push_back({8'h00, HDR_WORD0});
    exp_q.push_back({8'h00, HDR_WORD1});
    exp_q.push_back({8'h00, HDR_WORD2});
    for (int i = 0; i < p; i++)
      exp_q.push_back({(i == p - 1) ? 8'h01 : 8'h00,
                       (i == pi) ? pat : {seq, 24'h0, 8'(i)}});
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ~out_rdy;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    logic [71:0] e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      if (!out_rdy) check("wr_without_rdy", {63'h0, out_wr}, 64'h0);
      if (!busy)    check("wr_while_idle", {63'h0, out_wr}, 64'h0);
      if (out_wr) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_word: got %h/%h want no word", out_ctrl, out_data);
        end else begin
          e = exp_q.pop_front();
          check("word_ctrl", {56'h0, out_ctrl}, {56'h0, e[71:64]});
          check("word_data", out_data, e[63:0]);
        end
        if (out_ctrl == 8'hFF) begin
          if (chk_gap != 0 && last_end >= 0) check("gap_len", 64'(cyc - last_end), 64'(gap_m + 1));
          pkts_seen++;
          word_in_pkt = 0;
        end else word_in_pkt++;
        if (out_ctrl == 8'h01) last_end = cyc;
        if (cap_n < 64) begin
          cap_ctrl[cap_n] = out_ctrl;
          cap_data[cap_n] = out_data;
          cap_n++;
        end
      end
    end
  end

  task automatic run_burst(input int np, input int exp_pkts, input int pw, input int pi,
                           input int gap, input logic [15:0] dst, input logic [63:0] pat,
                           input logic with_abort);
    int p = (pw == 0) ? 1 : pw;
    gap_m = gap; last_end = -1; cap_n = 0; pkts_seen = 0;
    for (int k = 0; k < exp_pkts; k++) push_pkt(exp_sent + 32'(k), p, pi, dst, pat);
    exp_sent += 32'(exp_pkts);
    @(posedge clk); #1;
    cfg_num_pkts = 16'(np); cfg_payload_words = 8'(pw); cfg_pat_idx = 8'(pi);
    cfg_gap = 8'(gap); cfg_dst_port = dst; cfg_pattern = pat;
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    // config must have been latched; disturb the live inputs
    cfg_num_pkts = 16'($urandom); cfg_payload_words = 8'($urandom); cfg_pat_idx = 8'($urandom);
    cfg_gap = 8'($urandom); cfg_dst_port = 16'($urandom); cfg_pattern = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check({name, "_idle"}, {63'h0, busy}, 64'h0);
    check({name, "_left"}, 64'(exp_q.size()), 64'h0);
    check({name, "_sent"}, {32'h0, pkts_sent}, {32'h0, exp_sent});
  endtask

  task automatic do_clear();
    @(posedge clk); #1; clear_cnt = 1'b1;
    @(posedge clk); #1; clear_cnt = 1'b0;
    exp_sent = '0;
  endtask

  initial begin
    int fired;
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fired;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr",   {63'h0, out_wr}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_sent", {32'h0, pkts_sent}, 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_ctrl", {56'h0, out_ctrl}, 64'h0);
    reset = 1'b1;

    // single packet
    rdy_mode = 0; chk_gap = 1;
    run_burst(1, 1, 4, 2, 0, 16'h0004, 64'hCAFE_F00D_1234_5678, 1'b0);
    wait_idle("single");
    check("single_n",     64'(cap_n), 64'd8);
    check("single_c0",    {56'h0, cap_ctrl[0]}, 64'hFF);
    check("single_mod",   cap_data[0], 64'h0004_0007_0000_0038);
    check("single_c4",    {56'h0, cap_ctrl[4]}, 64'h00);
    check("single_p1",    cap_data[5], 64'h0000_0000_0000_0001);
    check("single_pat",   cap_data[6], 64'hCAFE_F00D_1234_5678);
    check("single_c7",    {56'h0, cap_ctrl[7]}, 64'h01);
    check("single_sent1", {32'h0, pkts_sent}, 64'd1);

    // backpressure
    rdy_mode = 1; chk_gap = 0;
    run_burst(1, 1, 4, 2, 0, 16'h0004, 64'hCAFE_F00D_1234_5678, 1'b0);
    wait_idle("bp");
    check("bp_n", 64'(cap_n), 64'd8);

    // pattern index past the payload
    rdy_mode = 0;
    run_burst(1, 1, 3, 5, 0, 16'h0002, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_idle("nopat");
    check("nopat_p0",  cap_data[4], 64'h0000_0002_0000_0000);
    check("nopat_p2",  cap_data[6], 64'h0000_0002_0000_0002);
    check("nopat_c6",  {56'h0, cap_ctrl[6]}, 64'h01);

    // burst with gap
    do_clear();
    check("clr_sent", {32'h0, pkts_sent}, 64'h0);
    chk_gap = 1;
    run_burst(3, 3, 2, 0, 4, 16'h0001, 64'h1111_2222_3333_4444, 1'b0);
    wait_idle("burst");
    check("burst_sent3", {32'h0, pkts_sent}, 64'd3);

    // abort in packet 2, word 5
    do_clear();
    run_burst(0, 2, 4, 3, 2, 16'h0010, 64'hABCD_0000_0000_ABCD, 1'b0);
    fired = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (out_wr && pkts_seen == 2 && word_in_pkt == 5) begin
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0; fired = 1;
        break;
      end
    end
    check("abort_fired", 64'(fired), 64'd1);
    wait_idle("abort");

    // clear on the last word's cycle wins over the increment
    do_clear();
    run_burst(1, 1, 2, 0, 0, 16'h0020, 64'h5555_5555_5555_5555, 1'b0);
    fired = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (out_wr && out_ctrl == 8'h01) begin
        clear_cnt = 1'b1; @(posedge clk); #1; clear_cnt = 1'b0; fired = 1;
        break;
      end
    end
    check("clr_fired", 64'(fired), 64'd1);
    exp_sent = '0;
    wait_idle("clrlast");

    // start and abort together: one packet only
    run_burst(3, 1, 1, 0, 1, 16'h0040, 64'h7777_0000_7777_0000, 1'b1);
    wait_idle("startabort");

    // abort in IDLE is ignored
    @(posedge clk); #1; abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    run_burst(2, 2, 1, 0, 0, 16'h0080, 64'h0, 1'b0);
    wait_idle("idleabort");

    // abort received during GAP
    chk_gap = 0;
    run_burst(0, 1, 2, 1, 6, 16'h0100, 64'h9999_8888_7777_6666, 1'b0);
    fired = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (out_wr && out_ctrl == 8'h01) begin
        @(posedge clk); #1; @(posedge clk); #1;
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0; fired = 1;
        break;
      end
    end
    check("gapabort_fired", 64'(fired), 64'd1);
    wait_idle("gapabort");

    // reset mid-packet at payload word 1
    run_burst(1, 1, 4, 9, 0, 16'h0200, 64'h0, 1'b0);
    fired = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (out_wr && word_in_pkt == 5) begin
        reset = 1'b0; fired = 1;
        break;
      end
    end
    check("rstmid_fired", 64'(fired), 64'd1);
    @(posedge clk); #1;
    exp_q.delete(); exp_sent = '0;
    @(negedge clk); #1;
    check("rstmid_wr",   {63'h0, out_wr}, 64'h0);
    check("rstmid_sent", {32'h0, pkts_sent}, 64'h0);
    reset = 1'b1;
    run_burst(1, 1, 2, 0, 0, 16'h0200, 64'h4242_4242_4242_4242, 1'b0);
    wait_idle("rstclean");
    check("rstclean_c0", {56'h0, cap_ctrl[0]}, 64'hFF);

    // randomized bursts with random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 10; t++) begin
      int np = $urandom_range(1, 3);
      run_burst(np, np, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3),
                16'(1 << $urandom_range(0, 15)), {$urandom, $urandom}, 1'b0);
      wait_idle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
